glitch_scheduler: RTL

Sequences fault injection on the PMIC supply DAC. It sits between the PMIC emulation core and the DAC pins and normally passes the core's nominal level straight through. When armed, it watches the decoded I2C byte stream for a configured byte. After a programmed delay it overrides the DAC with a glitch level, for a programmed width and repeat count, then hands the DAC back to the core.

---
 rtl/glitch_scheduler_pkg.sv | 18 +
 rtl/glitch_scheduler_if.sv | 33 +++
 rtl/glitch_scheduler_down_counter.sv | 19 +
 rtl/glitch_scheduler.sv | 86 ++++++++
 4 files changed

// File: rtl/glitch_scheduler_pkg.sv
// glitch_scheduler_pkg: state encodings, config reset values and trigger byte compare
package glitch_scheduler_pkg;
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ARMED  = 3'd1;
    localparam logic [2:0] S_DELAY  = 3'd2;
    localparam logic [2:0] S_GLITCH = 3'd3;
    localparam logic [2:0] S_GAP    = 3'd4;
    localparam int RST_DELAY = 0;
    localparam int RST_WIDTH = 1;
    localparam int RST_GAP   = 1;
    localparam logic [3:0] RST_REPEAT = 4'd0;
    localparam logic [7:0] RST_LEVEL  = 8'h00;
    localparam logic [7:0] RST_MATCH  = 8'h00;
    // The ack bit (bit 0) never takes part in the match.
    function automatic logic byte_match(logic [8:0] b, logic [7:0] m);
        return (b & 9'h1FE) == {m, 1'b0};
    endfunction
endpackage

// File: rtl/glitch_scheduler_if.sv
// glitch_scheduler_if: config, trigger and DAC signals of the glitch scheduler
interface glitch_scheduler_if #(
    parameter int DELAY_W = 32,
    parameter int WIDTH_W = 16
);
    logic               cfg_load;
    logic [DELAY_W-1:0] cfg_delay;
    logic [WIDTH_W-1:0] cfg_width;
    logic [WIDTH_W-1:0] cfg_gap;
    logic [3:0]         cfg_repeat;
    logic [7:0]         cfg_level;
    logic [7:0]         cfg_match;
    logic               arm;
    logic               disarm;
    logic [8:0]         trig_byte;
    logic               trig_valid;
    logic [7:0]         nominal_level;
    logic [7:0]         dac_level;
    logic               pulldown_trans;
    logic               busy;
    logic               done;
    logic [2:0]         state;
    modport master (
        output cfg_load, cfg_delay, cfg_width, cfg_gap, cfg_repeat, cfg_level, cfg_match,
        output arm, disarm, trig_byte, trig_valid, nominal_level,
        input  dac_level, pulldown_trans, busy, done, state
    );
    modport slave (
        input  cfg_load, cfg_delay, cfg_width, cfg_gap, cfg_repeat, cfg_level, cfg_match,
        input  arm, disarm, trig_byte, trig_valid, nominal_level,
        output dac_level, pulldown_trans, busy, done, state
    );
endinterface

// File: rtl/glitch_scheduler_down_counter.sv
// down_counter: loadable down counter that holds at zero instead of wrapping
module down_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         zero
);
    logic [W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = load ? load_val : (en && cnt_q != '0) ? cnt_q - W'(1) : cnt_q;
    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
    assign zero = cnt_q == '0;
endmodule

// File: rtl/glitch_scheduler.sv
// glitch_scheduler: overrides the PMIC DAC with a delayed, repeated glitch after a matching I2C byte
module glitch_scheduler
    import glitch_scheduler_pkg::*;
#(
    parameter int DELAY_W = 32,
    parameter int WIDTH_W = 16
) (
    input logic clk,
    input logic reset,
    glitch_scheduler_if.slave bus
);
    logic [2:0]         state_q, state_d;
    logic [DELAY_W-1:0] delay_q, delay_d;
    logic [WIDTH_W-1:0] width_q, width_d, gap_q, gap_d, len_val;
    logic [3:0]         repeat_q, repeat_d;
    logic [7:0]         level_q, level_d, match_q, match_d, dac_q, dac_d;
    logic               pd_q, pd_d, done_q, done_d;
    logic               cfg_en, fire, delay_zero, len_zero, last, len_load, len_en;
    always_comb begin
        cfg_en   = bus.cfg_load && state_q == S_IDLE;
        delay_d  = cfg_en ? bus.cfg_delay : delay_q;
        width_d  = cfg_en ? bus.cfg_width : width_q;
        gap_d    = cfg_en ? bus.cfg_gap : gap_q;
        repeat_d = cfg_en ? bus.cfg_repeat : repeat_q;
        level_d  = cfg_en ? bus.cfg_level : level_q;
        match_d  = cfg_en ? bus.cfg_match : match_q;
        fire     = state_q == S_ARMED && bus.trig_valid && byte_match(bus.trig_byte, match_q);
        state_d  = bus.disarm              ? S_IDLE :
                   state_q == S_IDLE   ? (bus.arm ? S_ARMED : S_IDLE) :
                   state_q == S_ARMED  ? (fire ? S_DELAY : S_ARMED) :
                   state_q == S_DELAY  ? (delay_zero ? S_GLITCH : S_DELAY) :
                   state_q == S_GLITCH ? (len_zero ? (last ? S_IDLE : S_GAP) : S_GLITCH) :
                   state_q == S_GAP    ? (len_zero ? S_GLITCH : S_GAP) : S_IDLE;
        // One counter times both pulse and gap; it reloads on every entry to either.
        len_load = (state_d == S_GLITCH && state_q != S_GLITCH) || (state_d == S_GAP && state_q != S_GAP);
        len_val  = state_d == S_GLITCH ? (width_q == '0 ? '0 : width_q - WIDTH_W'(1))
                                       : (gap_q == '0 ? '0 : gap_q - WIDTH_W'(1));
        len_en   = state_q == S_GLITCH || state_q == S_GAP;
        done_d   = state_q == S_GLITCH && len_zero && last && !bus.disarm;
        dac_d    = state_d == S_GLITCH ? level_q : bus.nominal_level;
        pd_d     = dac_d == 8'h00;
    end
    down_counter #(.W(DELAY_W)) u_delay (
        .clk(clk), .reset(reset), .load(fire), .en(state_q == S_DELAY),
        .load_val(delay_q), .zero(delay_zero)
    );
    down_counter #(.W(WIDTH_W)) u_len (
        .clk(clk), .reset(reset), .load(len_load), .en(len_en),
        .load_val(len_val), .zero(len_zero)
    );
    // Holds the pulses still to come after the current one, so zero marks the last pulse.
    down_counter #(.W(4)) u_pulse (
        .clk(clk), .reset(reset), .load(fire), .en(state_q == S_GLITCH && len_zero),
        .load_val(repeat_q), .zero(last)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            delay_q  <= DELAY_W'(RST_DELAY);
            width_q  <= WIDTH_W'(RST_WIDTH);
            gap_q    <= WIDTH_W'(RST_GAP);
            repeat_q <= RST_REPEAT;
            level_q  <= RST_LEVEL;
            match_q  <= RST_MATCH;
            dac_q    <= 8'h00;
            pd_q     <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            delay_q  <= delay_d;
            width_q  <= width_d;
            gap_q    <= gap_d;
            repeat_q <= repeat_d;
            level_q  <= level_d;
            match_q  <= match_d;
            dac_q    <= dac_d;
            pd_q     <= pd_d;
            done_q   <= done_d;
        end
    end
    assign bus.dac_level      = dac_q;
    assign bus.pulldown_trans = pd_q;
    assign bus.busy           = state_q != S_IDLE;
    assign bus.done           = done_q;
    assign bus.state          = state_q;
endmodule
